// File: rtl/issue_scoreboard_if.sv
// Decode-to-scoreboard bundle: the two issue slots, write-back/kill retire ports and
// the issue decisions plus debug state coming back.
interface issue_scoreboard_if #(
  parameter int unsigned CNT_W = 3
);
  logic             m_valid, m_wen, m_long;
  logic [4:0]       m_rs, m_rt, m_wa;
  logic             s_valid, s_wen, s_long;
  logic [4:0]       s_rs, s_rt, s_wa;
  logic             wb1_en, wb1_long, wb2_en, wb2_long, kill_en, flush;
  logic [4:0]       wb1_wa, wb2_wa, kill_wa;
  logic             issue_m, issue_s, stall;
  logic [31:0]      busy;
  logic [CNT_W-1:0] long_cnt;

  modport master (
    output m_valid, m_rs, m_rt, m_wen, m_wa, m_long,
           s_valid, s_rs, s_rt, s_wen, s_wa, s_long,
           wb1_en, wb1_wa, wb1_long, wb2_en, wb2_wa, wb2_long,
           kill_en, kill_wa, flush,
    input  issue_m, issue_s, stall, busy, long_cnt
  );

  modport slave (
    input  m_valid, m_rs, m_rt, m_wen, m_wa, m_long,
           s_valid, s_rs, s_rt, s_wen, s_wa, s_long,
           wb1_en, wb1_wa, wb1_long, wb2_en, wb2_wa, wb2_long,
           kill_en, kill_wa, flush,
    output issue_m, issue_s, stall, busy, long_cnt
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Dual-issue scoreboard: busy map of long-latency destinations plus an outstanding
// long-op counter; decides master then slave issue combinationally each cycle.
module issue_scoreboard #(
  parameter int unsigned MAX_LONG = 2,
  parameter int unsigned CNT_W    = 3
) (
  input logic              clk,
  input logic              rst,
  issue_scoreboard_if.slave sb
);

  localparam logic [CNT_W:0] MAX_C = MAX_LONG[CNT_W:0];

  function automatic logic [31:0] onehot(input logic en, input logic [4:0] wa);
    onehot = en ? (32'd1 << wa) : '0;
  endfunction

  logic [31:0]      busy_q, busy_d, clr, eb, set;
  logic [CNT_W-1:0] long_cnt_q, long_cnt_d, ec;
  logic             ev1, ev2, evk;
  logic [1:0]       ret;
  logic             hm, hs, issue_m, issue_s;

  always_comb begin
    ev1 = sb.wb1_en & sb.wb1_long;
    ev2 = sb.wb2_en & sb.wb2_long;
    evk = sb.kill_en;
    clr = onehot(ev1, sb.wb1_wa) | onehot(ev2, sb.wb2_wa) | onehot(evk, sb.kill_wa);
    ret = 2'(ev1) + 2'(ev2) + 2'(evk);
    // Write-backs this cycle count as free: the register file forwards them.
    eb  = busy_q & ~clr & ~32'd1;
    ec  = (CNT_W'(ret) > long_cnt_q) ? '0 : long_cnt_q - CNT_W'(ret);
  end

  always_comb begin
    hm = eb[sb.m_rs] | eb[sb.m_rt] | (sb.m_wen & eb[sb.m_wa])
       | (sb.m_long & ({1'b0, ec} >= MAX_C));
    hs = eb[sb.s_rs] | eb[sb.s_rt] | (sb.s_wen & eb[sb.s_wa])
       | (sb.m_wen && (sb.m_wa != 5'd0) && ((sb.m_wa == sb.s_rs) || (sb.m_wa == sb.s_rt)))
       | (sb.m_long & sb.s_long)
       | (sb.s_long & (({1'b0, ec} + {{CNT_W{1'b0}}, sb.m_long}) >= MAX_C));
    issue_m = sb.m_valid & ~sb.flush & ~hm & ~rst;
    issue_s = issue_m & sb.s_valid & ~hs;
  end

  always_comb begin
    set        = onehot(issue_m & sb.m_long & sb.m_wen, sb.m_wa)
               | onehot(issue_s & sb.s_long & sb.s_wen, sb.s_wa);
    busy_d     = (eb | set) & ~32'd1;
    long_cnt_d = ec + {{(CNT_W-1){1'b0}}, issue_m & sb.m_long}
                    + {{(CNT_W-1){1'b0}}, issue_s & sb.s_long};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      long_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      long_cnt_q <= long_cnt_d;
    end
  end

  // Retire-port protocol: no counter underflow, no two retires to the same register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (CNT_W'(ret) <= long_cnt_q)
        else $error("issue_scoreboard: long-op counter underflow");
      assert (!((ev1 && ev2 && sb.wb1_wa == sb.wb2_wa && sb.wb1_wa != 5'd0) ||
                (ev1 && evk && sb.wb1_wa == sb.kill_wa && sb.wb1_wa != 5'd0) ||
                (ev2 && evk && sb.wb2_wa == sb.kill_wa && sb.wb2_wa != 5'd0)))
        else $error("issue_scoreboard: duplicate retire address");
    end
  end

  assign sb.issue_m  = issue_m;
  assign sb.issue_s  = issue_s;
  assign sb.stall    = sb.m_valid & ~issue_m & ~rst;
  assign sb.busy     = busy_q;
  assign sb.long_cnt = long_cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard with MAX_LONG = 2.
module tb_issue_scoreboard;
  localparam int unsigned CNT_W = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  issue_scoreboard_if #(.CNT_W(CNT_W)) sbif ();

  issue_scoreboard #(.MAX_LONG(2), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbif.slave)
  );

  task automatic idle();
    sbif.m_valid = 0; sbif.m_rs = 0; sbif.m_rt = 0; sbif.m_wen = 0; sbif.m_wa = 0; sbif.m_long = 0;
    sbif.s_valid = 0; sbif.s_rs = 0; sbif.s_rt = 0; sbif.s_wen = 0; sbif.s_wa = 0; sbif.s_long = 0;
    sbif.wb1_en = 0; sbif.wb1_wa = 0; sbif.wb1_long = 0;
    sbif.wb2_en = 0; sbif.wb2_wa = 0; sbif.wb2_long = 0;
    sbif.kill_en = 0; sbif.kill_wa = 0; sbif.flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; idle(); sbif.m_valid = 1;
    step(); step(); #1;
    checks++; if (sbif.issue_m !== 1'b0) begin errors++; $display("FAIL reset_issue_m: got %b exp 0", sbif.issue_m); end
    checks++; if (sbif.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", sbif.stall); end
    checks++; if (sbif.busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h exp 0", sbif.busy); end
    checks++; if (sbif.long_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", sbif.long_cnt); end
    rst = 0; idle();
  endtask

  task automatic test_raw_long();
    sbif.m_valid = 1; sbif.m_rs = 1; sbif.m_rt = 2; sbif.m_wen = 1; sbif.m_wa = 5; sbif.m_long = 1;
    sbif.s_valid = 1; sbif.s_rs = 5; sbif.s_rt = 0; sbif.s_wen = 1; sbif.s_wa = 6;
    #1;
    checks++; if (sbif.issue_m !== 1'b1) begin errors++; $display("FAIL raw_issue_m: got %b exp 1", sbif.issue_m); end
    checks++; if (sbif.issue_s !== 1'b0) begin errors++; $display("FAIL raw_issue_s: got %b exp 0", sbif.issue_s); end
    step(); idle(); #1;
    checks++; if (sbif.busy !== 32'h20) begin errors++; $display("FAIL raw_busy: got %h exp 00000020", sbif.busy); end
    checks++; if (sbif.long_cnt !== 3'd1) begin errors++; $display("FAIL raw_cnt: got %0d exp 1", sbif.long_cnt); end
  endtask

  task automatic test_wb_forward();
    sbif.m_valid = 1; sbif.m_rs = 5; sbif.m_wen = 1; sbif.m_wa = 10;
    #1;
    checks++; if (sbif.stall !== 1'b1) begin errors++; $display("FAIL fwd_stall: got %b exp 1", sbif.stall); end
    sbif.wb1_en = 1; sbif.wb1_wa = 5; sbif.wb1_long = 1;
    #1;
    checks++; if (sbif.issue_m !== 1'b1) begin errors++; $display("FAIL fwd_issue_m: got %b exp 1", sbif.issue_m); end
    step(); idle(); #1;
    checks++; if (sbif.busy !== 32'h0) begin errors++; $display("FAIL fwd_busy: got %h exp 0", sbif.busy); end
    checks++; if (sbif.long_cnt !== 3'd0) begin errors++; $display("FAIL fwd_cnt: got %0d exp 0", sbif.long_cnt); end
  endtask

  task automatic test_long_cap();
    sbif.m_valid = 1; sbif.m_wen = 1; sbif.m_wa = 1; sbif.m_long = 1;
    sbif.s_valid = 1; sbif.s_wen = 1; sbif.s_wa = 2; sbif.s_long = 1;
    #1;
    checks++; if (sbif.issue_m !== 1'b1) begin errors++; $display("FAIL pair_long_issue_m: got %b exp 1", sbif.issue_m); end
    checks++; if (sbif.issue_s !== 1'b0) begin errors++; $display("FAIL pair_long_issue_s: got %b exp 0", sbif.issue_s); end
    step(); idle();
    sbif.m_valid = 1; sbif.m_wen = 1; sbif.m_wa = 11;
    sbif.s_valid = 1; sbif.s_wen = 1; sbif.s_wa = 2; sbif.s_long = 1;
    #1;
    checks++; if (sbif.issue_s !== 1'b1) begin errors++; $display("FAIL slave_long_issue_s: got %b exp 1", sbif.issue_s); end
    step(); idle(); #1;
    checks++; if (sbif.busy !== 32'h6) begin errors++; $display("FAIL cap_busy: got %h exp 00000006", sbif.busy); end
    checks++; if (sbif.long_cnt !== 3'd2) begin errors++; $display("FAIL cap_cnt: got %0d exp 2", sbif.long_cnt); end
    sbif.m_valid = 1; sbif.m_wen = 1; sbif.m_wa = 7; sbif.m_long = 1;
    #1;
    checks++; if (sbif.stall !== 1'b1) begin errors++; $display("FAIL cap_stall: got %b exp 1", sbif.stall); end
    sbif.wb2_en = 1; sbif.wb2_wa = 2; sbif.wb2_long = 1;
    #1;
    checks++; if (sbif.issue_m !== 1'b1) begin errors++; $display("FAIL cap_retire_issue_m: got %b exp 1", sbif.issue_m); end
    step(); idle(); #1;
    checks++; if (sbif.busy !== 32'h82) begin errors++; $display("FAIL cap_retire_busy: got %h exp 00000082", sbif.busy); end
    checks++; if (sbif.long_cnt !== 3'd2) begin errors++; $display("FAIL cap_retire_cnt: got %0d exp 2", sbif.long_cnt); end
  endtask

  task automatic test_intra_pair();
    sbif.m_valid = 1; sbif.m_rs = 8; sbif.m_rt = 9; sbif.m_wen = 1; sbif.m_wa = 3;
    sbif.s_valid = 1; sbif.s_rs = 3; sbif.s_wen = 1; sbif.s_wa = 12;
    #1;
    checks++; if (sbif.issue_m !== 1'b1) begin errors++; $display("FAIL intra_issue_m: got %b exp 1", sbif.issue_m); end
    checks++; if (sbif.issue_s !== 1'b0) begin errors++; $display("FAIL intra_issue_s: got %b exp 0", sbif.issue_s); end
    sbif.m_wa = 0; sbif.s_rs = 0; sbif.s_rt = 0; sbif.s_wa = 13;
    #1;
    checks++; if (sbif.issue_s !== 1'b1) begin errors++; $display("FAIL r0_issue_s: got %b exp 1", sbif.issue_s); end
    sbif.m_wa = 14; sbif.s_wa = 7;
    #1;
    checks++; if (sbif.issue_s !== 1'b0) begin errors++; $display("FAIL slave_waw_issue_s: got %b exp 0", sbif.issue_s); end
    step(); idle(); #1;
    checks++; if (sbif.busy !== 32'h82) begin errors++; $display("FAIL intra_busy: got %h exp 00000082", sbif.busy); end
  endtask

  task automatic test_kill_flush();
    sbif.m_valid = 1; sbif.m_wen = 1; sbif.m_wa = 9; sbif.m_long = 1;
    sbif.wb1_en = 1; sbif.wb1_wa = 1; sbif.wb1_long = 1;
    step(); idle(); #1;
    checks++; if (sbif.busy !== 32'h280) begin errors++; $display("FAIL kill_setup_busy: got %h exp 00000280", sbif.busy); end
    sbif.m_valid = 1; sbif.m_wen = 1; sbif.m_wa = 9;
    #1;
    checks++; if (sbif.stall !== 1'b1) begin errors++; $display("FAIL master_waw_stall: got %b exp 1", sbif.stall); end
    idle(); sbif.kill_en = 1; sbif.kill_wa = 9;
    step(); idle(); #1;
    checks++; if (sbif.busy !== 32'h80) begin errors++; $display("FAIL kill_busy: got %h exp 00000080", sbif.busy); end
    checks++; if (sbif.long_cnt !== 3'd1) begin errors++; $display("FAIL kill_cnt: got %0d exp 1", sbif.long_cnt); end
    sbif.flush = 1; sbif.m_valid = 1; sbif.s_valid = 1;
    #1;
    checks++; if (sbif.issue_m !== 1'b0) begin errors++; $display("FAIL flush_issue_m: got %b exp 0", sbif.issue_m); end
    checks++; if (sbif.issue_s !== 1'b0) begin errors++; $display("FAIL flush_issue_s: got %b exp 0", sbif.issue_s); end
    checks++; if (sbif.stall !== 1'b1) begin errors++; $display("FAIL flush_stall: got %b exp 1", sbif.stall); end
    step(); idle(); #1;
    checks++; if (sbif.busy !== 32'h80) begin errors++; $display("FAIL flush_busy: got %h exp 00000080", sbif.busy); end
  endtask

  task automatic test_set_over_clear();
    sbif.m_valid = 1; sbif.m_wen = 1; sbif.m_wa = 4; sbif.m_long = 1;
    step(); idle(); #1;
    checks++; if (sbif.busy !== 32'h90) begin errors++; $display("FAIL soc_setup_busy: got %h exp 00000090", sbif.busy); end
    sbif.m_valid = 1; sbif.m_wen = 1; sbif.m_wa = 4; sbif.m_long = 1;
    sbif.wb1_en = 1; sbif.wb1_wa = 4; sbif.wb1_long = 1;
    #1;
    checks++; if (sbif.issue_m !== 1'b1) begin errors++; $display("FAIL soc_issue_m: got %b exp 1", sbif.issue_m); end
    step(); idle(); #1;
    checks++; if (sbif.busy !== 32'h90) begin errors++; $display("FAIL soc_busy: got %h exp 00000090", sbif.busy); end
    checks++; if (sbif.long_cnt !== 3'd2) begin errors++; $display("FAIL soc_cnt: got %0d exp 2", sbif.long_cnt); end
    rst = 1; sbif.m_valid = 1;
    #1;
    checks++; if (sbif.issue_m !== 1'b0) begin errors++; $display("FAIL midrst_issue_m: got %b exp 0", sbif.issue_m); end
    step(); #1;
    checks++; if (sbif.busy !== 32'h0) begin errors++; $display("FAIL midrst_busy: got %h exp 0", sbif.busy); end
    checks++; if (sbif.long_cnt !== 3'd0) begin errors++; $display("FAIL midrst_cnt: got %0d exp 0", sbif.long_cnt); end
    rst = 0; idle();
  endtask

  task automatic test_long_nowen();
    sbif.m_valid = 1; sbif.m_long = 1;
    #1;
    checks++; if (sbif.issue_m !== 1'b1) begin errors++; $display("FAIL nowen_issue_m: got %b exp 1", sbif.issue_m); end
    step(); idle(); #1;
    checks++; if (sbif.long_cnt !== 3'd1) begin errors++; $display("FAIL nowen_cnt: got %0d exp 1", sbif.long_cnt); end
    sbif.wb2_en = 1; sbif.wb2_wa = 0; sbif.wb2_long = 1;
    step(); idle(); #1;
    checks++; if (sbif.long_cnt !== 3'd0) begin errors++; $display("FAIL nowen_retire_cnt: got %0d exp 0", sbif.long_cnt); end
    checks++; if (sbif.busy !== 32'h0) begin errors++; $display("FAIL nowen_busy: got %h exp 0", sbif.busy); end
  endtask

  initial begin
    test_reset();
    test_raw_long();
    test_wb_forward();
    test_long_cap();
    test_intra_pair();
    test_kill_flush();
    test_set_over_clear();
    test_long_nowen();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Dual-issue scheduler between decode and the 4-read/2-write register file.
- Tracks destination registers of in-flight long-latency ops (load, mul/div) in a 32-bit busy map and caps how many are outstanding.
- Each cycle decides whether the master slot, and then the slave slot, may issue.
- Resolves RAW and WAW hazards against long-latency producers, plus intra-pair dependencies between master and slave.

Parameters:
MAX_LONG, 2, maximum outstanding long-latency ops (1..7)
CNT_W, 3, width of the outstanding-op counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m_valid  in  1  master slot holds a decoded instruction
m_rs  in  5  master source A
m_rt  in  5  master source B
m_wen  in  1  master writes a register
m_wa  in  5  master destination
m_long  in  1  master is long-latency
s_valid  in  1  slave slot holds a decoded instruction
s_rs  in  5  slave source A
s_rt  in  5  slave source B
s_wen  in  1  slave writes a register
s_wa  in  5  slave destination
s_long  in  1  slave is long-latency
wb1_en  in  1  master-pipe write-back
wb1_wa  in  5  master-pipe write-back address
wb1_long  in  1  master-pipe write-back is from a long op
wb2_en  in  1  slave-pipe write-back
wb2_wa  in  5  slave-pipe write-back address
wb2_long  in  1  slave-pipe write-back is from a long op
kill_en  in  1  an in-flight long op was squashed
kill_wa  in  5  destination of the squashed op
flush  in  1  suppress all issue this cycle
issue_m  out  1  master issues this cycle
issue_s  out  1  slave issues this cycle
stall  out  1  m_valid && !issue_m
busy  out  32  registered busy map (debug)
long_cnt  out  CNT_W  registered outstanding long-op count

Behaviour:
- Reset: busy = 0, long_cnt = 0. Outputs issue_m, issue_s, stall are combinational and therefore 0 whenever rst = 1.
- Retire clears, computed combinationally each cycle:
  - clr = (wb1_en & wb1_long) << wb1_wa | (wb2_en & wb2_long) << wb2_wa | kill_en << kill_wa.
  - ret = number of those three events asserted. Duplicate addresses are not allowed (protocol assertion).
- Effective busy: eb = busy & ~clr. A register written back this cycle counts as free, matching the register file's write-back forwarding. Bit 0 of eb is always 0.
- Effective count: ec = long_cnt - ret.
- Master hazard, hm, is any of:
  - m_rs busy in eb;
  - m_rt busy in eb;
  - m_wen and m_wa busy in eb (WAW);
  - m_long and ec >= MAX_LONG.
- issue_m = m_valid & ~flush & ~hm & ~rst.
- Slave hazard, hs, is any of:
  - the same eb checks applied to s_rs, s_rt and s_wa;
  - m_wen and m_wa != 0 and m_wa equals s_rs or s_rt (intra-pair RAW);
  - m_long and s_long both set (one long unit per pair);
  - s_long and ec + m_long >= MAX_LONG.
- issue_s = issue_m & s_valid & ~hs. The slave never issues without the master (in-order).
- Sequential update on the clock edge:
  - busy <= eb | set, where set = (issue_m & m_long & m_wen) << m_wa | (issue_s & s_long & s_wen) << s_wa, with bit 0 forced to 0. Set wins over clear on the same address.
  - long_cnt <= ec + (issue_m & m_long) + (issue_s & s_long).
- A long op with wen = 0 still counts toward long_cnt. Its retire arrives as wbX_long with wa = 0, which decrements the count and leaves the map unchanged.
- Counter underflow (ret > long_cnt) is a protocol error. Flag it with an assertion; the counter saturates at 0.
- Reset mid-operation: busy map and counter clear in the same edge; late write-backs after reset only decrement a count that is already 0, so they saturate.
- Latency: decision is 0-cycle combinational. A new busy bit is visible to the next cycle's decision. A write-back frees its register in the same cycle.

Test Plan:
1. After reset, issue master lw to $5 (m_long = 1), slave addu $6 <- $5 -> issue_m = 1, issue_s = 0; the next cycle busy[5] = 1, long_cnt = 1.
2. busy[5] set; master reads $5 while wb1_en = 1, wb1_wa = 5, wb1_long = 1 in the same cycle -> issue_m = 1; busy[5] = 0 after the edge.
3. MAX_LONG = 2 with two outstanding loads; master lw $7 -> stall = 1. In the same cycle wb2 retires one long op -> issue_m = 1, long_cnt stays 2.
4. Master addu $3 <- ..., slave uses $3 -> issue_m = 1, issue_s = 0. Master writes $0, slave reads $0 -> both issue.
5. busy[9] set, kill_en = 1 with kill_wa = 9 -> busy[9] = 0 and long_cnt decremented. Assert flush with all-clear inputs -> issue_m = issue_s = 0 and the map is unchanged.
6. Retire $4 via wb1 and issue a new lw $4 in the same cycle -> busy[4] = 1 after the edge, count net unchanged. Then assert rst -> busy = 0, long_cnt = 0.
